// File: rtl/aim_filter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : aim_filter_pkg
// Description : Shared types and constants for the aim_filter block: the
//               tracker state encoding, active-video limits and an in-frame
//               coordinate check.
// Revision    : 1.0 - initial release
// ============================================================================
package aim_filter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        TRACK   = 2'd2,
        HOLD    = 2'd3
    } track_state_t;

    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;

    // Largest legal coordinate on each axis (inclusive)
    localparam logic [9:0] c_X_MAX = 10'(H_ACTIVE - 1);
    localparam logic [9:0] c_Y_MAX = 10'(V_ACTIVE - 1);

    // A coordinate pair inside the active picture area
    function automatic logic in_frame(input logic [9:0] x, input logic [9:0] y);
        return (x <= c_X_MAX) && (y <= c_Y_MAX);
    endfunction

endpackage : aim_filter_pkg
`default_nettype wire

// File: rtl/ema_axis.sv
`default_nettype none
// ============================================================================
// Module      : ema_axis
// Description : One axis of the aim-point smoother. Holds the filtered
//               coordinate f; 'load' copies the sample directly, 'update'
//               applies f += (sample - f) >>> ALPHA_SHIFT with floor
//               rounding. 'limit' is the inclusive axis maximum and bounds
//               the result. With AIM_FILTER_DEADBAND_EN defined, an update
//               whose |sample - f| <= DEADBAND leaves f unchanged.
// Revision    : 1.0 - initial release
// ============================================================================
module ema_axis
    import aim_filter_pkg::*;
#(
    parameter int ALPHA_SHIFT = 2,
    parameter int DEADBAND    = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] sample,
    input  logic       load,
    input  logic       update,
    input  logic [9:0] limit,
    output logic [9:0] f
);

`ifdef AIM_FILTER_DEADBAND_EN
    localparam logic c_DB_EN = 1'b1;
`else
    localparam logic c_DB_EN = 1'b0;
`endif

    logic [9:0]        r_f;
    logic signed [10:0] w_d;
    logic signed [10:0] w_step;
    logic [10:0]       w_abs;
    logic [9:0]        w_sum;
    logic [9:0]        w_next;
    logic              w_in_db;
    logic              w_hold;

    // Signed error, floor-rounded step and candidate next value
    always_comb begin
        w_d     = $signed({1'b0, sample}) - $signed({1'b0, r_f});
        w_step  = w_d >>> ALPHA_SHIFT;
        // 10-bit modular add is the required truncation; the true result
        // is a convex combination of f and sample so it cannot wrap.
        w_sum   = r_f + w_step[9:0];
        w_next  = (w_sum > limit) ? limit : w_sum;
        w_abs   = w_d[10] ? 11'(-w_d) : 11'(w_d);
        w_in_db = (w_abs <= 11'(DEADBAND));
        w_hold  = c_DB_EN && w_in_db;
    end

    // Filter register: direct load wins, dead-band only gates EMA updates
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_f <= 10'd0;
        end else if (load) begin
            r_f <= sample;
        end else if (update && !w_hold) begin
            r_f <= w_next;
        end
    end

    assign f = r_f;

endmodule : ema_axis
`default_nettype wire

// File: rtl/aim_filter.sv
`default_nettype none
// ============================================================================
// Module      : aim_filter
// Description : Per-frame aim-point stabiliser. On each falling edge of
//               v_sync the tracker sample is taken, an IDLE/ACQUIRE/TRACK/
//               HOLD machine advances, and X/Y are smoothed by two ema_axis
//               instances. All outputs are registered and change only on
//               the cycle after a frame edge, flagged by frame_tick.
//               Optional feature macro: AIM_FILTER_DEADBAND_EN (per-axis
//               dead-band on EMA updates).
// Revision    : 1.0 - initial release
// ============================================================================
module aim_filter
    import aim_filter_pkg::*;
#(
    parameter int ACQ_FRAMES  = 3,
    parameter int HOLD_FRAMES = 8,
    parameter int ALPHA_SHIFT = 2,
    parameter int DEADBAND    = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       v_sync,
    input  logic [9:0] aim_x,
    input  logic [9:0] aim_y,
    input  logic       aim_detected,
    output logic [9:0] filt_x,
    output logic [9:0] filt_y,
    output logic       filt_valid,
    output logic [1:0] track_state,
    output logic       frame_tick,
    output logic [7:0] lost_cnt
);

    localparam logic [3:0] c_ACQ_FRAMES  = 4'(ACQ_FRAMES);
    localparam logic [7:0] c_HOLD_FRAMES = 8'(HOLD_FRAMES);

    track_state_t r_state;
    track_state_t w_state_nxt;
    logic [3:0]   r_acq_cnt;
    logic [3:0]   w_acq_nxt;
    logic [3:0]   w_acq_inc;
    logic [7:0]   r_lost_cnt;
    logic [7:0]   w_lost_nxt;
    logic [7:0]   w_lost_inc;
    logic         r_vs_q;
    logic         r_valid;
    logic         r_tick;
    logic         w_edge;
    logic         w_det;
    logic         w_load;
    logic         w_update;

    // Frame boundary and effective detect (out-of-picture counts as a miss)
    assign w_edge     = r_vs_q & ~v_sync;
    assign w_det      = aim_detected & in_frame(aim_x, aim_y);
    assign w_acq_inc  = r_acq_cnt + 4'd1;
    assign w_lost_inc = r_lost_cnt + 8'd1;

    // Next-state, counter and filter-control logic, active only on an edge
    always_comb begin
        w_state_nxt = r_state;
        w_acq_nxt   = r_acq_cnt;
        w_lost_nxt  = r_lost_cnt;
        w_load      = 1'b0;
        w_update    = 1'b0;
        if (w_edge) begin
            case (r_state)
                IDLE: begin
                    if (w_det) begin
                        if (c_ACQ_FRAMES == 4'd1) begin
                            w_state_nxt = TRACK;
                            w_acq_nxt   = 4'd0;
                            w_load      = 1'b1;
                        end else begin
                            w_state_nxt = ACQUIRE;
                            w_acq_nxt   = 4'd1;
                        end
                    end
                end
                ACQUIRE: begin
                    if (w_det) begin
                        if (w_acq_inc >= c_ACQ_FRAMES) begin
                            w_state_nxt = TRACK;
                            w_acq_nxt   = 4'd0;
                            w_load      = 1'b1;
                        end else begin
                            w_acq_nxt   = w_acq_inc;
                        end
                    end else begin
                        w_state_nxt = IDLE;
                        w_acq_nxt   = 4'd0;
                    end
                end
                TRACK: begin
                    if (w_det) begin
                        w_update = 1'b1;
                    end else if (c_HOLD_FRAMES == 8'd1) begin
                        // A single tolerated miss is already exhausted
                        w_state_nxt = IDLE;
                        w_lost_nxt  = 8'd0;
                    end else begin
                        w_state_nxt = HOLD;
                        w_lost_nxt  = 8'd1;
                    end
                end
                HOLD: begin
                    if (w_det) begin
                        w_state_nxt = TRACK;
                        w_lost_nxt  = 8'd0;
                        w_update    = 1'b1;
                    end else if (w_lost_inc >= c_HOLD_FRAMES) begin
                        w_state_nxt = IDLE;
                        w_lost_nxt  = 8'd0;
                    end else begin
                        w_lost_nxt  = w_lost_inc;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_acq_nxt   = 4'd0;
                    w_lost_nxt  = 8'd0;
                end
            endcase
        end
    end

    // State, counters, validity and tick registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // vs_q clears low so an edge coincident with reset release is
            // not seen; v_sync must be observed high first.
            r_vs_q     <= 1'b0;
            r_state    <= IDLE;
            r_acq_cnt  <= 4'd0;
            r_lost_cnt <= 8'd0;
            r_valid    <= 1'b0;
            r_tick     <= 1'b0;
        end else begin
            r_vs_q     <= v_sync;
            r_state    <= w_state_nxt;
            r_acq_cnt  <= w_acq_nxt;
            r_lost_cnt <= w_lost_nxt;
            r_valid    <= (w_state_nxt == TRACK) || (w_state_nxt == HOLD);
            r_tick     <= w_edge;
        end
    end

    ema_axis #(
        .ALPHA_SHIFT (ALPHA_SHIFT),
        .DEADBAND    (DEADBAND)
    ) u_ema_x (
        .clk    (clk),
        .reset  (reset),
        .sample (aim_x),
        .load   (w_load),
        .update (w_update),
        .limit  (c_X_MAX),
        .f      (filt_x)
    );

    ema_axis #(
        .ALPHA_SHIFT (ALPHA_SHIFT),
        .DEADBAND    (DEADBAND)
    ) u_ema_y (
        .clk    (clk),
        .reset  (reset),
        .sample (aim_y),
        .load   (w_load),
        .update (w_update),
        .limit  (c_Y_MAX),
        .f      (filt_y)
    );

    assign filt_valid  = r_valid;
    assign track_state = r_state;
    assign frame_tick  = r_tick;
    assign lost_cnt    = r_lost_cnt;

endmodule : aim_filter
`default_nettype wire

// File: tb/tb_aim_filter.sv
`default_nettype none
// ============================================================================
// Module      : tb_aim_filter
// Description : Scoreboard bench for aim_filter. Each frame pushes its
//               hand-computed expected outputs; a monitor pops and checks
//               on every frame_tick.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aim_filter;

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_ACQ   = 2'd1;
    localparam logic [1:0] c_TRACK = 2'd2;
    localparam logic [1:0] c_HOLD  = 2'd3;

    typedef struct packed {
        logic [1:0] st;
        logic       v;
        logic [9:0] fx;
        logic [9:0] fy;
        logic [7:0] lost;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       v_sync;
    logic [9:0] aim_x;
    logic [9:0] aim_y;
    logic       aim_detected;
    logic [9:0] filt_x;
    logic [9:0] filt_y;
    logic       filt_valid;
    logic [1:0] track_state;
    logic       frame_tick;
    logic [7:0] lost_cnt;

    exp_t q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    aim_filter u_dut (
        .clk          (clk),
        .reset        (reset),
        .v_sync       (v_sync),
        .aim_x        (aim_x),
        .aim_y        (aim_y),
        .aim_detected (aim_detected),
        .filt_x       (filt_x),
        .filt_y       (filt_y),
        .filt_valid   (filt_valid),
        .track_state  (track_state),
        .frame_tick   (frame_tick),
        .lost_cnt     (lost_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every tick must match the oldest expectation
    always @(negedge clk) begin : mon
        exp_t e;
        if (!reset && frame_tick) begin
            if (q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_tick: got tick, expected none (t=%0t)", $time);
            end else begin
                e = q.pop_front();
                chk("track_state", 32'(track_state), 32'(e.st));
                chk("filt_valid",  32'(filt_valid),  32'(e.v));
                chk("filt_x",      32'(filt_x),      32'(e.fx));
                chk("filt_y",      32'(filt_y),      32'(e.fy));
                chk("lost_cnt",    32'(lost_cnt),    32'(e.lost));
            end
        end
    end

    // One frame: sample presented in the edge cycle, then scrambled
    task automatic frame(input logic det, input logic [9:0] x, input logic [9:0] y,
                         input logic [1:0] st, input logic v,
                         input logic [9:0] fx, input logic [9:0] fy, input logic [7:0] lost);
        @(negedge clk);
        aim_detected = det;
        aim_x        = x;
        aim_y        = y;
        q.push_back('{st: st, v: v, fx: fx, fy: fy, lost: lost});
        v_sync = 1'b0;
        @(negedge clk);
        aim_detected = ~det;
        aim_x        = ~x;
        aim_y        = x;
        repeat (2) @(negedge clk);
        v_sync = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_filt_x"},     32'(filt_x),      32'd0);
        chk({tag, "_filt_y"},     32'(filt_y),      32'd0);
        chk({tag, "_filt_valid"}, 32'(filt_valid),  32'd0);
        chk({tag, "_state"},      32'(track_state), 32'(c_IDLE));
        chk({tag, "_tick"},       32'(frame_tick),  32'd0);
        chk({tag, "_lost"},       32'(lost_cnt),    32'd0);
    endtask

    initial begin
        reset        = 1'b1;
        v_sync       = 1'b1;
        aim_x        = 10'd0;
        aim_y        = 10'd0;
        aim_detected = 1'b0;
        #1;
        chk_reset_values("por");
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        // Acquire and track
        frame(1'b1, 10'd100, 10'd50, c_ACQ,   1'b0, 10'd0,   10'd0,  8'd0);
        frame(1'b1, 10'd100, 10'd50, c_ACQ,   1'b0, 10'd0,   10'd0,  8'd0);
        frame(1'b1, 10'd100, 10'd50, c_TRACK, 1'b1, 10'd100, 10'd50, 8'd0);
        frame(1'b1, 10'd120, 10'd50, c_TRACK, 1'b1, 10'd105, 10'd50, 8'd0);

        // Hold for 5 misses, then recover with an EMA step
        for (int i = 1; i <= 5; i++)
            frame(1'b0, 10'd300, 10'd300, c_HOLD, 1'b1, 10'd105, 10'd50, 8'(i));
        frame(1'b1, 10'd125, 10'd70, c_TRACK, 1'b1, 10'd110, 10'd55, 8'd0);

        // Hold timeout after 8 misses
        for (int i = 1; i <= 7; i++)
            frame(1'b0, 10'd0, 10'd0, c_HOLD, 1'b1, 10'd110, 10'd55, 8'(i));
        frame(1'b0, 10'd0, 10'd0, c_IDLE, 1'b0, 10'd110, 10'd55, 8'd0);

        // Acquire abort via out-of-range X, and out-of-range Y from IDLE
        frame(1'b1, 10'd10,  10'd10,  c_ACQ,  1'b0, 10'd110, 10'd55, 8'd0);
        frame(1'b1, 10'd10,  10'd10,  c_ACQ,  1'b0, 10'd110, 10'd55, 8'd0);
        frame(1'b1, 10'd640, 10'd10,  c_IDLE, 1'b0, 10'd110, 10'd55, 8'd0);
        frame(1'b1, 10'd10,  10'd480, c_IDLE, 1'b0, 10'd110, 10'd55, 8'd0);

        // Upper in-range corner acquires and loads directly
        frame(1'b1, 10'd639, 10'd479, c_ACQ,   1'b0, 10'd110, 10'd55,  8'd0);
        frame(1'b1, 10'd639, 10'd479, c_ACQ,   1'b0, 10'd110, 10'd55,  8'd0);
        frame(1'b1, 10'd639, 10'd479, c_TRACK, 1'b1, 10'd639, 10'd479, 8'd0);

        // Input activity away from the edge cycle is ignored
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            aim_detected = ~aim_detected;
            aim_x        = 10'(i * 37);
            aim_y        = 10'(i * 11);
        end
        @(negedge clk);
        chk("quiet_filt_x", 32'(filt_x),      32'd639);
        chk("quiet_filt_y", 32'(filt_y),      32'd479);
        chk("quiet_state",  32'(track_state), 32'(c_TRACK));
        chk("quiet_valid",  32'(filt_valid),  32'd1);

        // Asynchronous reset mid-frame while tracking
        #2;
        reset = 1'b1;
        #1;
        chk_reset_values("mid");
        // Edge coincident with reset release must be ignored
        @(negedge clk);
        v_sync = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        v_sync = 1'b1;
        repeat (3) @(negedge clk);
        chk("rel_state", 32'(track_state), 32'(c_IDLE));

        // First edge after reset processed normally; EMA rounding corners
        frame(1'b1, 10'd200, 10'd200, c_ACQ,   1'b0, 10'd0,   10'd0,   8'd0);
        frame(1'b1, 10'd200, 10'd200, c_ACQ,   1'b0, 10'd0,   10'd0,   8'd0);
        frame(1'b1, 10'd200, 10'd200, c_TRACK, 1'b1, 10'd200, 10'd200, 8'd0);
        frame(1'b1, 10'd202, 10'd202, c_TRACK, 1'b1, 10'd200, 10'd200, 8'd0);
        frame(1'b1, 10'd196, 10'd212, c_TRACK, 1'b1, 10'd199, 10'd203, 8'd0);
        frame(1'b1, 10'd201, 10'd198, c_TRACK, 1'b1, 10'd199, 10'd201, 8'd0);
`ifdef AIM_FILTER_DEADBAND_EN
        frame(1'b1, 10'd197, 10'd201, c_TRACK, 1'b1, 10'd199, 10'd201, 8'd0);
`else
        frame(1'b1, 10'd197, 10'd201, c_TRACK, 1'b1, 10'd198, 10'd201, 8'd0);
`endif

        for (int i = 0; i < 50 && q.size() != 0; i++) @(negedge clk);
        if (q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL tick_timeout: got %0d pending, expected 0", q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_aim_filter
`default_nettype wire
